// File: rtl/ascon_permutation_engine.sv
// ascon_permutation_engine
//   Self-sequenced ASCON permutation p^12 / p^8 / p^6 over the 320-bit state
//   {x0,x1,x2,x3,x4} (x0 in bits [319:256]). A job is accepted on start_i.
//   The accept cycle already applies the first ROUNDS_PER_CYCLE rounds to
//   state_i. Each RUN cycle applies ROUNDS_PER_CYCLE more rounds to the
//   registered state. done_o pulses once on the edge that applies the last round.
//
// Parameters
//   ROUNDS_PER_CYCLE  rounds chained combinationally per clock (1 or 2)
//
// Ports
//   clock_i      in   1    clock, rising edge
//   resetb_i     in   1    asynchronous reset, active low
//   start_i      in   1    job request (ignored while a job is running)
//   abort_i      in   1    abandon the running job (only with ASCON_PERM_ABORT_EN)
//   nb_rounds_i  in   2    00=12, 01=8, 10=6, 11=12 rounds
//   state_i      in   320  input state, sampled in the accept cycle only
//   busy_o       out  1    job in progress
//   done_o       out  1    one-cycle pulse, state_o holds the final state
//   state_o      out  320  state register
//
// Optional feature macro: ASCON_PERM_ABORT_EN (adds abort_i)

module ascon_permutation_engine #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic [1:0]   nb_rounds_i,
    input  logic [319:0] state_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [319:0] state_o
);

    localparam int unsigned STATE_W = 320;
    localparam int unsigned WORD_W  = 64;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] IDX_END = 4'd12;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2)) begin : g_bad_rpc
        $error("ascon_permutation_engine: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    // 5-bit ASCON S-box, input/output bit order {x0,x1,x2,x3,x4}
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x,
                                                input int unsigned    n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // One full round: constant add on x2, column-wise S-box, linear diffusion
    function automatic logic [STATE_W-1:0] ascon_round(input logic [STATE_W-1:0] s,
                                                      input logic [CNT_W-1:0]   idx);
        logic [WORD_W-1:0] x0, x1, x2, x3, x4;
        logic [4:0]        col;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {{(WORD_W - 8){1'b0}}, 4'(4'hf - idx), idx};
        for (int i = 0; i < int'(WORD_W); i++) begin
            col = SBOX[{x0[i], x1[i], x2[i], x3[i], x4[i]}];
            {x0[i], x1[i], x2[i], x3[i], x4[i]} = col;
        end
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2,  1) ^ ror64(x2,  6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4,  7) ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    fsm_e               fsm_q,   fsm_d;
    logic [CNT_W-1:0]   round_q, round_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               accept;
    logic               abort_req;
    logic               last_step;
    logic [CNT_W-1:0]   first_idx;
    logic [CNT_W-1:0]   base_idx;
    logic [CNT_W-1:0]   step_idx;
    logic [STATE_W-1:0] round_in;
    logic [STATE_W-1:0] round_out;

`ifdef ASCON_PERM_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    // Starting constant index so that every job finishes on index 11
    always_comb begin : first_index
        case (nb_rounds_i)
            2'b01:   first_idx = 4'd4;
            2'b10:   first_idx = 4'd6;
            default: first_idx = 4'd0;
        endcase
    end

    // Accept is possible from IDLE and from DONE (back-to-back jobs)
    assign accept    = start_i && (fsm_q != S_RUN);
    assign base_idx  = accept ? first_idx : round_q;
    assign round_in  = accept ? state_i : state_q;
    assign step_idx  = base_idx + CNT_W'(ROUNDS_PER_CYCLE);
    assign last_step = (step_idx == IDX_END);

    // ROUNDS_PER_CYCLE rounds chained combinationally
    always_comb begin : round_chain
        round_out = round_in;
        for (int unsigned k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            round_out = ascon_round(round_out, base_idx + CNT_W'(k));
        end
    end

    // Next-state and registered-output logic
    always_comb begin : next_state
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            S_RUN: begin
                if (abort_req) begin
                    fsm_d  = S_IDLE;
                    busy_d = 1'b0;
                end else begin
                    state_d = round_out;
                    round_d = step_idx;
                    if (last_step) begin
                        fsm_d  = S_DONE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                fsm_d  = S_IDLE;
                busy_d = 1'b0;
                if (accept) begin
                    state_d = round_out;
                    round_d = step_idx;
                    busy_d  = 1'b1;
                    fsm_d   = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin : regs
        if (!resetb_i) begin
            fsm_q   <= S_IDLE;
            round_q <= '0;
            state_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// tb_ascon_permutation_engine
//   Bench for ascon_permutation_engine with one instance per legal
//   ROUNDS_PER_CYCLE (1 and 2). Expected states come from a word-oriented
//   reference model of the ASCON permutation. Expected done cycles are queued
//   at job start and checked when done_o appears.
//   Builds with or without ASCON_PERM_ABORT_EN.

module tb_ascon_permutation_engine;

    localparam int unsigned SW = 320;

    typedef struct {
        logic [SW-1:0] st;
        int unsigned   cyc;
    } sb_t;

    typedef struct {
        logic [1:0]    nb;
        logic [SW-1:0] st_in;
        int unsigned   rounds;
        int unsigned   lat1;
        int unsigned   lat2;
        logic [SW-1:0] exp_st;
    } vec_t;

    logic          clk    = 1'b0;
    logic          resetb = 1'b1;
    logic          start1 = 1'b0;
    logic          start2 = 1'b0;
    logic [1:0]    nb     = 2'b00;
    logic [SW-1:0] st_in  = '0;
`ifdef ASCON_PERM_ABORT_EN
    logic          abort  = 1'b0;
`endif
    logic          busy1, done1, busy2, done2;
    logic [SW-1:0] st1, st2;

    int unsigned cyc     = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    sb_t         q1[$];
    sb_t         q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_permutation_engine #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clock_i     (clk),
        .resetb_i    (resetb),
        .start_i     (start1),
`ifdef ASCON_PERM_ABORT_EN
        .abort_i     (abort),
`endif
        .nb_rounds_i (nb),
        .state_i     (st_in),
        .busy_o      (busy1),
        .done_o      (done1),
        .state_o     (st1)
    );

    ascon_permutation_engine #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clock_i     (clk),
        .resetb_i    (resetb),
        .start_i     (start2),
`ifdef ASCON_PERM_ABORT_EN
        .abort_i     (abort),
`endif
        .nb_rounds_i (nb),
        .state_i     (st_in),
        .busy_o      (busy2),
        .done_o      (done2),
        .state_o     (st2)
    );

    // Reference permutation, bitsliced as in the C reference
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [SW-1:0] model_perm(input logic [SW-1:0] s, input int nr);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int r = 12 - nr; r < 12; r++) begin
            x2 ^= 64'(((15 - r) << 4) | r);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2,  1) ^ ror(x2,  6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4,  7) ^ ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumers
    always @(negedge clk) begin : mon1
        sb_t e;
        if (resetb && done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected done_o", done1, 1'b0);
            end else begin
                e = q1.pop_front();
                chk("dut1 result", st1, e.st);
                chk("dut1 done cycle", cyc, e.cyc);
                chk("dut1 busy at done", busy1, 1'b0);
            end
        end
    end

    always @(negedge clk) begin : mon2
        sb_t e;
        if (resetb && done2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("dut2 unexpected done_o", done2, 1'b0);
            end else begin
                e = q2.pop_front();
                chk("dut2 result", st2, e.st);
                chk("dut2 done cycle", cyc, e.cyc);
                chk("dut2 busy at done", busy2, 1'b0);
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q1.size() == 0 && q2.size() == 0) return;
            @(negedge clk);
        end
        chk("scoreboard drain timeout", SW'(q1.size() + q2.size()), '0);
        q1.delete();
        q2.delete();
    endtask

    // Pulse start for one cycle, queue the expectation, then scramble the
    // inputs the engine must no longer look at
    task automatic start_job(input int id, input logic [1:0] nbv, input logic [SW-1:0] stv,
                             input logic [SW-1:0] exp, input int unsigned lat);
        @(negedge clk);
        nb    = nbv;
        st_in = stv;
        if (id == 1) begin
            start1 = 1'b1;
            q1.push_back('{exp, cyc + lat});
        end else begin
            start2 = 1'b1;
            q2.push_back('{exp, cyc + lat});
        end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        nb     = 2'b10;
        st_in  = {$urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom};
        chk($sformatf("dut%0d busy after accept", id), (id == 1) ? busy1 : busy2, 1'b1);
    endtask

    initial begin : main
        vec_t          vt[6];
        logic [SW-1:0] iv_st, rnd_st, a_st, b_st, hold;

        iv_st  = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                  64'h0001020304050607, 64'h08090a0b0c0d0e0f};
        rnd_st = {$urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom};

        vt[0] = '{2'b00, iv_st,  12, 12, 6, '0};
        vt[1] = '{2'b01, iv_st,   8,  8, 4, '0};
        vt[2] = '{2'b10, iv_st,   6,  6, 3, '0};
        vt[3] = '{2'b11, iv_st,  12, 12, 6, '0};
        vt[4] = '{2'b00, rnd_st, 12, 12, 6, '0};
        vt[5] = '{2'b10, rnd_st,  6,  6, 3, '0};
        for (int i = 0; i < 6; i++) vt[i].exp_st = model_perm(vt[i].st_in, int'(vt[i].rounds));

        // Reset values
        #1 resetb = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset dut1 state_o", st1, '0);
        chk("reset dut1 busy_o", busy1, 1'b0);
        chk("reset dut1 done_o", done1, 1'b0);
        chk("reset dut2 state_o", st2, '0);
        chk("reset dut2 busy_o", busy2, 1'b0);
        chk("reset dut2 done_o", done2, 1'b0);
        resetb = 1'b1;

        // Round-count sweep on both instances
        for (int i = 0; i < 6; i++) begin
            start_job(1, vt[i].nb, vt[i].st_in, vt[i].exp_st, vt[i].lat1);
            start_job(2, vt[i].nb, vt[i].st_in, vt[i].exp_st, vt[i].lat2);
            wait_drain(40);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d dut1 idle hold", i), st1, vt[i].exp_st);
            chk($sformatf("vec%0d dut2 idle hold", i), st2, vt[i].exp_st);
        end

        // Back-to-back: start held across DONE
        a_st = rnd_st;
        b_st = iv_st ^ rnd_st;
        @(negedge clk);
        nb     = 2'b00;
        st_in  = a_st;
        start1 = 1'b1;
        q1.push_back('{model_perm(a_st, 12), cyc + 12});
        q1.push_back('{model_perm(b_st, 12), cyc + 24});
        @(negedge clk);
        st_in = b_st;
        repeat (12) @(negedge clk);
        start1 = 1'b0;
        chk("b2b busy after second accept", busy1, 1'b1);
        wait_drain(40);

        // start_i mid-job is ignored
        start_job(1, 2'b00, iv_st, vt[0].exp_st, 12);
        repeat (4) @(negedge clk);
        nb     = 2'b10;
        st_in  = rnd_st;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("busy while start ignored", busy1, 1'b1);
            @(negedge clk);
        end
        wait_drain(30);

        // Reset mid-job abandons it
        start_job(1, 2'b00, rnd_st, vt[4].exp_st, 12);
        repeat (6) @(negedge clk);
        resetb = 1'b0;
        #1;
        chk("mid reset state_o", st1, '0);
        chk("mid reset busy_o", busy1, 1'b0);
        chk("mid reset done_o", done1, 1'b0);
        q1.delete();
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        repeat (14) @(negedge clk);
        start_job(1, 2'b01, iv_st, vt[1].exp_st, 8);
        wait_drain(30);

`ifdef ASCON_PERM_ABORT_EN
        // Abort in RUN
        start_job(1, 2'b00, iv_st, vt[0].exp_st, 12);
        repeat (2) @(negedge clk);
        hold  = st1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy_o", busy1, 1'b0);
        chk("abort state held", st1, hold);
        q1.delete();
        repeat (15) @(negedge clk);
        chk("abort no restart busy_o", busy1, 1'b0);
        chk("abort state still held", st1, hold);

        // Abort wins over start in RUN
        start_job(1, 2'b00, rnd_st, vt[4].exp_st, 12);
        repeat (2) @(negedge clk);
        hold   = st1;
        abort  = 1'b1;
        start1 = 1'b1;
        st_in  = iv_st;
        @(negedge clk);
        abort  = 1'b0;
        start1 = 1'b0;
        chk("abort+start busy_o", busy1, 1'b0);
        chk("abort+start state held", st1, hold);
        q1.delete();
        repeat (3) @(negedge clk);

        // Abort outside RUN is ignored
        abort = 1'b1;
        start_job(1, 2'b10, iv_st, vt[2].exp_st, 6);
        abort = 1'b0;
        wait_drain(30);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
